// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// and fills the IF/ID register while tolerating decode stalls and branch redirects.
module if_fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            imem_rvalid,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr
);

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned ALIGN_MASK  = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t          r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_pc;
    logic            r_hold_valid;
    logic [XLEN-1:0] r_hold_pc;
    logic [XLEN-1:0] r_hold_instr;
    logic            r_if_id_valid;
    logic [XLEN-1:0] r_if_id_pc;
    logic [XLEN-1:0] r_if_id_instr;

    logic w_rsp;
    logic w_req;
    logic w_fire;

    // A response is only meaningful while WAIT; a new fetch may overlap a consumed response.
    always_comb begin
        w_rsp  = 1'b0;
        w_req  = 1'b0;
        w_fire = 1'b0;
        w_rsp  = (r_state == S_WAIT) && imem_rvalid;
        w_req  = rst && !redirect && !r_hold_valid &&
                 ((r_state == S_IDLE) || (w_rsp && !stall));
        w_fire = w_req && imem_gnt;
    end

    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_req_pc      <= '0;
            r_hold_valid  <= 1'b0;
            r_hold_pc     <= '0;
            r_hold_instr  <= '0;
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= NOP_INSTR;
        end else if (redirect) begin
            // Flush wins over stall; an outstanding request must be drained in DROP.
            r_pc          <= redirect_pc & ~XLEN'(ALIGN_MASK);
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            r_hold_valid  <= 1'b0;
            if ((r_state != S_IDLE) && !imem_rvalid) begin
                r_state <= S_DROP;
            end else begin
                r_state <= S_IDLE;
            end
        end else begin
            if (w_fire) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + XLEN'(INSTR_BYTES);
                r_state  <= S_WAIT;
            end else if ((r_state != S_IDLE) && imem_rvalid) begin
                r_state <= S_IDLE;
            end

            if (w_rsp && stall) begin
                r_hold_valid <= 1'b1;
                r_hold_pc    <= r_req_pc;
                r_hold_instr <= imem_rdata;
            end

            if (!stall) begin
                if (r_hold_valid) begin
                    r_if_id_valid <= 1'b1;
                    r_if_id_pc    <= r_hold_pc;
                    r_if_id_instr <= r_hold_instr;
                    r_hold_valid  <= 1'b0;
                end else if (w_rsp) begin
                    r_if_id_valid <= 1'b1;
                    r_if_id_pc    <= r_req_pc;
                    r_if_id_instr <= imem_rdata;
                end else begin
                    r_if_id_valid <= 1'b0;
                    r_if_id_instr <= NOP_INSTR;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus randomized traffic, with a
// program-order scoreboard checking every instruction decode accepts.
module tb_if_fetch_stage;

    localparam logic [31:0] XORK = 32'hA5A5_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst         = 1'b0;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;

    logic        mem_auto = 1'b0;
    logic        d_gnt    = 1'b0;
    logic        d_rvalid = 1'b0;
    logic [31:0] d_rdata  = '0;
    logic        m_gnt    = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata  = '0;

    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    logic        wrap_req;
    logic [31:0] wrap_addr;
    logic        wrap_valid;
    logic [31:0] wrap_pc;
    logic [31:0] wrap_instr;

    assign imem_gnt    = mem_auto ? m_gnt    : d_gnt;
    assign imem_rvalid = mem_auto ? m_rvalid : d_rvalid;
    assign imem_rdata  = mem_auto ? m_rdata  : d_rdata;

    if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0013)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr)
    );

    // Always-granting, always-responding memory: exercises PC wraparound at the top of memory.
    if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0013)) u_wrap (
        .clk(clk), .rst(rst),
        .imem_req(wrap_req), .imem_addr(wrap_addr), .imem_gnt(1'b1),
        .imem_rdata(32'h1234_5678), .imem_rvalid(1'b1),
        .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
        .if_id_valid(wrap_valid), .if_id_pc(wrap_pc), .if_id_instr(wrap_instr)
    );

    int errors   = 0;
    int checks   = 0;
    int consumed = 0;
    int lat_min  = 1;
    int lat_max  = 1;
    int gnt_pct  = 100;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order restarts at start: decode must see start, start+4, ...
    task automatic sb_restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 256; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: decode accepts IF/ID on an edge with valid, no stall and no flush.
    always @(negedge clk) begin
        if (rst && if_id_valid && !stall && !redirect) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: got pc %h expected no instruction", if_id_pc);
            end else begin
                sb_exp = exp_q.pop_front();
                chk("sb_pc", if_id_pc, sb_exp);
                chk("sb_instr", if_id_instr, sb_exp ^ XORK);
                consumed++;
                if (exp_q.size() < 32 && exp_q.size() > 0) begin
                    for (int i = 0; i < 64; i++) exp_q.push_back(exp_q[$] + 32'd4);
                end
            end
        end
    end

    // In-order memory with random grant and a random response latency of lat_min..lat_max.
    initial begin : mem_model
        logic        fired;
        logic [31:0] faddr;
        logic        pend;
        logic [31:0] paddr;
        int          cnt;
        pend = 1'b0;
        paddr = '0;
        cnt = 0;
        forever begin
            @(negedge clk);
            fired = imem_req && imem_gnt;
            faddr = imem_addr;
            @(posedge clk);
            #1;
            if (!mem_auto) begin
                pend     = 1'b0;
                m_rvalid = 1'b0;
                m_gnt    = 1'b0;
            end else begin
                m_rvalid = 1'b0;
                if (fired) begin
                    chk("one_outstanding", 32'(pend), 32'd0);
                    pend  = 1'b1;
                    paddr = faddr;
                    cnt   = int'($urandom_range(lat_max, lat_min)) - 1;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        m_rvalid = 1'b1;
                        m_rdata  = paddr ^ XORK;
                        pend     = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                m_gnt = (int'($urandom_range(99)) < gnt_pct);
            end
        end
    end

    initial begin : stim
        int start_cnt;
        // Reset values while rst is held low.
        tick();
        tick();
        @(negedge clk);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", 32'(if_id_valid), 32'd0);
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_instr", if_id_instr, NOP);
        mem_auto = 1'b1;
        tick();
        rst = 1'b1;
        sb_restart(32'h0);

        // Streaming with single-cycle memory: one fetch per cycle.
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            chk("stream_addr", imem_addr, 32'(4 * (n - 1)));
            chk("stream_req", 32'(imem_req), 32'd1);
            if (n <= 2) begin
                chk("stream_pre_valid", 32'(if_id_valid), 32'd0);
                chk("stream_pre_instr", if_id_instr, NOP);
            end else begin
                chk("stream_pc", if_id_pc, 32'(4 * (n - 3)));
            end
            if (n == 1) begin
                chk("wrap_addr0", wrap_addr, 32'hFFFF_FFFC);
                chk("wrap_req0", 32'(wrap_req), 32'd1);
            end
            if (n == 2) chk("wrap_addr1", wrap_addr, 32'h0000_0000);
            if (n == 3) begin
                chk("wrap_valid", 32'(wrap_valid), 32'd1);
                chk("wrap_pc", wrap_pc, 32'hFFFF_FFFC);
                chk("wrap_instr", wrap_instr, 32'h1234_5678);
            end
            tick();
        end

        // Three stall cycles: IF/ID frozen, one response held, no new requests.
        stall = 1'b1;
        for (int n = 7; n <= 9; n++) begin
            @(negedge clk);
            chk("stall_req", 32'(imem_req), 32'd0);
            chk("stall_pc", if_id_pc, 32'h10);
            chk("stall_valid", 32'(if_id_valid), 32'd1);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("hold_req", 32'(imem_req), 32'd0);
        tick();
        @(negedge clk);
        chk("hold_pc", if_id_pc, 32'h14);
        chk("resume_addr", imem_addr, 32'h18);
        tick();
        repeat (3) tick();

        // Manual memory: redirect while a delayed response is in flight.
        mem_auto = 1'b0;
        d_gnt = 1'b0;
        d_rvalid = 1'b0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sb_restart(32'h0);
        redirect = 1'b1;
        redirect_pc = 32'h8;
        sb_restart(32'h8);
        @(negedge clk);
        chk("redir_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        d_gnt = 1'b1;
        @(negedge clk);
        chk("grant8_addr", imem_addr, 32'h8);
        chk("grant8_req", 32'(imem_req), 32'd1);
        tick();
        d_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        sb_restart(32'h100);
        @(negedge clk);
        chk("redir2_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        chk("drop_req", 32'(imem_req), 32'd0);
        tick();
        d_rvalid = 1'b1;
        d_rdata = 32'h8 ^ XORK;
        @(negedge clk);
        chk("drop_rsp_req", 32'(imem_req), 32'd0);
        tick();
        d_rvalid = 1'b0;
        d_gnt = 1'b1;
        @(negedge clk);
        chk("after_drop_req", 32'(imem_req), 32'd1);
        chk("after_drop_addr", imem_addr, 32'h100);
        chk("stale_discarded", 32'(if_id_valid), 32'd0);
        tick();
        d_gnt = 1'b0;
        d_rvalid = 1'b1;
        d_rdata = 32'h100 ^ XORK;
        tick();
        d_rvalid = 1'b0;
        stall = 1'b1;
        d_gnt = 1'b1;
        @(negedge clk);
        chk("redir_tgt_valid", 32'(if_id_valid), 32'd1);
        chk("redir_tgt_pc", if_id_pc, 32'h100);
        chk("redir_tgt_instr", if_id_instr, 32'h100 ^ XORK);
        chk("stall_idle_addr", imem_addr, 32'h104);
        tick();

        // Redirect coinciding with rvalid under stall: flush wins.
        d_gnt = 1'b0;
        d_rvalid = 1'b1;
        d_rdata = 32'h104 ^ XORK;
        redirect = 1'b1;
        redirect_pc = 32'h40;
        sb_restart(32'h40);
        @(negedge clk);
        chk("flush_req", 32'(imem_req), 32'd0);
        tick();
        redirect = 1'b0;
        d_rvalid = 1'b0;
        d_gnt = 1'b1;
        @(negedge clk);
        chk("flush_valid", 32'(if_id_valid), 32'd0);
        chk("flush_instr", if_id_instr, NOP);
        chk("flush_addr", imem_addr, 32'h40);
        chk("flush_next_req", 32'(imem_req), 32'd1);
        tick();
        stall = 1'b0;
        d_gnt = 1'b0;
        d_rvalid = 1'b1;
        d_rdata = 32'h40 ^ XORK;
        tick();
        d_rvalid = 1'b0;
        d_gnt = 1'b1;
        @(negedge clk);
        chk("after_flush_pc", if_id_pc, 32'h40);
        chk("after_flush_addr", imem_addr, 32'h44);
        tick();

        // Asynchronous reset while WAIT, then a late stale response.
        d_gnt = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", 32'(imem_req), 32'd0);
        chk("arst_addr", imem_addr, 32'h0);
        chk("arst_valid", 32'(if_id_valid), 32'd0);
        chk("arst_pc", if_id_pc, 32'h0);
        chk("arst_instr", if_id_instr, NOP);
        tick();
        rst = 1'b1;
        sb_restart(32'h0);
        d_rvalid = 1'b1;
        d_rdata = 32'h44 ^ XORK;
        @(negedge clk);
        chk("late_req", 32'(imem_req), 32'd1);
        chk("late_addr", imem_addr, 32'h0);
        tick();
        d_rvalid = 1'b0;
        d_gnt = 1'b1;
        @(negedge clk);
        chk("late_ignored", 32'(if_id_valid), 32'd0);
        chk("first_fetch", imem_addr, 32'h0);
        tick();
        d_gnt = 1'b0;
        d_rvalid = 1'b1;
        d_rdata = 32'h0 ^ XORK;
        tick();
        d_rvalid = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 32'(if_id_valid), 32'd1);
        chk("post_rst_pc", if_id_pc, 32'h0);
        tick();

        // Randomized traffic: grants, latency, stalls and redirects.
        rst = 1'b0;
        mem_auto = 1'b1;
        lat_min = 1;
        lat_max = 4;
        gnt_pct = 70;
        tick();
        rst = 1'b1;
        sb_restart(32'h0);
        start_cnt = consumed;
        for (int c = 0; c < 3000; c++) begin
            if (c == 2000) begin
                lat_max = 1;
                gnt_pct = 100;
            end
            stall = (c >= 2000) ? ($urandom_range(15) == 0) : ($urandom_range(3) == 0);
            redirect = ($urandom_range(29) == 0);
            if (redirect) begin
                redirect_pc = $urandom;
                sb_restart(redirect_pc & ~32'h3);
            end
            tick();
        end
        stall = 1'b0;
        redirect = 1'b0;
        repeat (20) tick();
        chk("progress", 32'(consumed - start_cnt > 800), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
